dcache_controller: RTL and testbench
====================================

// Module: dcache_controller
// PURPOSE
//  Controller for the RISC-V core's direct-mapped data cache. Owns tag/valid/data
//  arrays; sequences line refills and write-through stores to word-addressed main
//  memory; stalls the core while memory is busy. Write-through, no-write-allocate.
//  Sits between the core's load/store port and the main memory module.
// PARAMETERS
//  ADDR_W    10  word-address width from the core
//  DATA_W    32  data word width
//  INDEX_W   4   line index bits (16 lines)
//  OFFSET_W  2   word-in-line bits (4 words/line); TAG_W = ADDR_W-INDEX_W-OFFSET_W
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous reset, active-high
//  cpu_rd     in   1       load request (held by core while stall=1)
//  cpu_wr     in   1       store request (held by core while stall=1)
//  cpu_addr   in   ADDR_W  word address {tag,index,offset}
//  cpu_wdata  in   DATA_W  store data
//  cpu_rdata  out  DATA_W  load data, valid when cpu_rd=1 and stall=0
//  stall      out  1       core must hold request and not advance
//  mem_rd     out  1       memory read request
//  mem_wr     out  1       memory write request
//  mem_addr   out  ADDR_W  memory word address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid with mem_ready
//  mem_ready  in   1       memory completes current request this cycle
//  hit_cnt    out  16      load hits (wraps)
//  miss_cnt   out  16      load misses (wraps)
// BEHAVIOUR
//  Reset: state=IDLE; all valid bits cleared same edge; stall, mem_rd, mem_wr=0;
//   mem_addr, mem_wdata, cpu_rdata=0; counters=0. Reset mid-REFILL/WRITE aborts;
//   partially filled line stays invalid; no further mem request issued.
//  Memory handshake: request level-held with stable mem_addr/mem_wdata until a
//   clock edge sampling mem_ready=1; one word per handshake; mem_ready outside
//   REFILL/WRITE ignored. Next request may start the following cycle.
//  States: IDLE, REFILL, WRITE.
//  IDLE, cpu_rd, hit (valid & tag match): cpu_rdata = line word, same-cycle
//   (combinational); stall=0; hit_cnt+1 unless this is the replay cycle.
//  IDLE, cpu_rd, miss: stall=1 same cycle; miss_cnt+1; latch line base address
//   {tag,index,0}; -> REFILL.
//  REFILL: stall=1; mem_rd=1, mem_addr=base+word_ctr (0..3 in order); each
//   mem_ready writes mem_rdata to data[index][word_ctr], ctr+1. On the 4th
//   mem_ready: set tag, valid=1; -> IDLE with replay flag set. Replay cycle hits,
//   stall=0, not counted. Min miss penalty = 4 memory handshakes + 1 replay cycle.
//  IDLE, cpu_wr: stall=1; if hit, data word updated at this edge (miss: cache
//   untouched); latch addr/data; -> WRITE.
//  WRITE: mem_wr=1; stall=1 until cycle mem_ready=1, where stall=0
//   (combinational) so core retires the store at that edge; -> IDLE.
//  cpu_rd and cpu_wr both high: treated as write; read ignored.
//  Store to a line never evicts; load miss overwrites line unconditionally
//   (write-through: nothing dirty).
//  Changing cpu_addr while stall=1 is a core protocol violation; unspecified.
//  Counters wrap 16'hFFFF -> 0.
// TESTING
//  1. Reset, load 0x010 (mem[0x010..0x013]=A..D) -> stall, mem_rd at 0x010..0x013
//     in order, replay returns A; miss_cnt=1, hit_cnt=0.
//  2. Then load 0x013 -> D same cycle, stall=0, no mem_rd; hit_cnt=1.
//  3. Store 0x55 to 0x011 with mem_ready delayed 3 cycles -> mem_wr held, addr and
//     data stable, stall drops on ready cycle; later load 0x011 hits with 0x55.
//  4. Load 0x050 (same index, new tag) after test 1 -> refill evicts; load 0x010
//     misses again; miss_cnt=3.
//  5. Assert rst after 2nd refill word -> mem_rd=0 next cycle; load 0x010 then
//     misses and refills all 4 words.
//  6. cpu_rd=cpu_wr=1 at 0x020 -> single mem_wr, no mem_rd, counters unchanged.

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Refills a whole line on a load miss and forwards every store to main memory.
module dcache_controller #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);
  // state  | meaning
  // IDLE   | serve load hits, accept new requests
  // REFILL | fetch the four words of a missed line, in order
  // WRITE  | forward a store to memory, stall until it completes
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  localparam int LINE_W = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tags [LINES];
  logic [DATA_W-1:0]       data [LINES*WORDS];

  logic [LINE_W-1:0]       base_line;
  logic [OFFSET_W-1:0]     word_ctr;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    replay;

  logic [TAG_W-1:0]          cpu_tag;
  logic [INDEX_W-1:0]        cpu_index;
  logic [INDEX_W+OFFSET_W-1:0] cpu_word;
  logic [INDEX_W-1:0]        base_index;
  logic [TAG_W-1:0]          base_tag;
  logic                      hit;

  logic hit_inc, miss_inc, store_hit, start_write, refill_beat, refill_last;

  assign cpu_tag    = cpu_addr[ADDR_W-1 -: TAG_W];
  assign cpu_index  = cpu_addr[OFFSET_W +: INDEX_W];
  assign cpu_word   = cpu_addr[INDEX_W+OFFSET_W-1:0];
  assign base_index = base_line[INDEX_W-1:0];
  assign base_tag   = base_line[LINE_W-1 -: TAG_W];
  assign hit        = valid[cpu_index] && (tags[cpu_index] == cpu_tag);

  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    cpu_rdata   = '0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    store_hit   = 1'b0;
    start_write = 1'b0;
    refill_beat = 1'b0;
    refill_last = 1'b0;
    case (state)
      IDLE: begin
        // a simultaneous read and write is handled purely as a store
        if (cpu_wr) begin
          stall       = 1'b1;
          start_write = 1'b1;
          store_hit   = hit;
          state_nxt   = WRITE;
        end else if (cpu_rd) begin
          if (hit) begin
            cpu_rdata = data[cpu_word];
            hit_inc   = !replay;
          end else begin
            stall     = 1'b1;
            miss_inc  = 1'b1;
            state_nxt = REFILL;
          end
        end
      end
      REFILL: begin
        stall    = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = {base_line, word_ctr};
        if (mem_ready) begin
          refill_beat = 1'b1;
          if (word_ctr == OFFSET_W'(WORDS-1)) begin
            refill_last = 1'b1;
            state_nxt   = IDLE;
          end
        end
      end
      WRITE: begin
        mem_wr    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        stall     = !mem_ready;
        if (mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      base_line <= '0;
      word_ctr  <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      replay    <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      state  <= state_nxt;
      replay <= refill_last;
      if (hit_inc)  hit_cnt  <= hit_cnt + 16'd1;
      if (miss_inc) begin
        miss_cnt         <= miss_cnt + 16'd1;
        base_line        <= cpu_addr[ADDR_W-1:OFFSET_W];
        word_ctr         <= '0;
        valid[cpu_index] <= 1'b0;
      end
      if (refill_beat) word_ctr <= word_ctr + 1'b1;
      if (refill_last) valid[base_index] <= 1'b1;
      if (start_write) begin
        wr_addr <= cpu_addr;
        wr_data <= cpu_wdata;
      end
    end
  end

  // arrays carry no reset; valid bits alone qualify their contents
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (refill_beat) data[{base_index, word_ctr}] <= mem_rdata;
      if (store_hit)   data[cpu_word] <= cpu_wdata;
      if (refill_last) tags[base_index] <= base_tag;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: vector table of load/store accesses
// against a word-addressed memory model, plus delayed-store and mid-refill reset sequences.
module tb_dcache_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd, cpu_wr;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        stall, mem_rd, mem_wr, mem_ready;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [15:0] hit_cnt, miss_cnt;

  dcache_controller dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int a);
    return 32'hC0DE_0000 | a;
  endfunction

  // memory model: answers after `lat` waiting cycles of a held request
  logic [31:0] mem [1024];
  int lat = 0, wait_cnt = 0, rd_hs = 0, wr_hs = 0;
  logic [9:0] rd_log [$];

  assign mem_ready = (mem_rd || mem_wr) && (wait_cnt == lat);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (rst) wait_cnt <= 0;
    else if (mem_ready) begin
      wait_cnt <= 0;
      if (mem_wr) begin
        mem[mem_addr] <= mem_wdata;
        wr_hs <= wr_hs + 1;
      end
      if (mem_rd) begin
        rd_hs <= rd_hs + 1;
        rd_log.push_back(mem_addr);
      end
    end else if (mem_rd || mem_wr) wait_cnt <= wait_cnt + 1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd, wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          lat;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
    logic [15:0] exp_hit, exp_miss;
    int          exp_rd_hs, exp_wr_hs;
    logic        exp_stall0;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [9:0] addr,
                              input logic [31:0] wdata, input int l, input logic cr,
                              input logic [31:0] er, input logic [15:0] eh,
                              input logic [15:0] em, input int erh, input int ewh,
                              input logic es);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.lat = l;
    v.chk_rdata = cr; v.exp_rdata = er; v.exp_hit = eh; v.exp_miss = em;
    v.exp_rd_hs = erh; v.exp_wr_hs = ewh; v.exp_stall0 = es;
    return v;
  endfunction

  // drive one request until the core may retire it; called at posedge+#1
  task automatic access(input vec_t v, output logic [31:0] rdata,
                        output logic stall0, output logic to);
    cpu_rd = v.rd; cpu_wr = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata; lat = v.lat;
    to = 1'b1; rdata = '0; stall0 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) stall0 = stall;
      if (!stall) begin
        rdata = cpu_rdata;
        to = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  vec_t vecs [12];
  logic [9:0] exp_log [$];

  initial begin
    logic [31:0] rdata;
    logic s0, to;
    int rb, wb;
    vec_t v;

    for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
    vecs[0]  = mk(1, 0, 10'h010, 0,        0, 1, init_val('h010), 0, 1, 4, 0, 1);
    vecs[1]  = mk(1, 0, 10'h013, 0,        0, 1, init_val('h013), 1, 1, 0, 0, 0);
    vecs[2]  = mk(0, 1, 10'h011, 'h55,     2, 0, 0,               1, 1, 0, 1, 1);
    vecs[3]  = mk(1, 0, 10'h011, 0,        0, 1, 'h55,            2, 1, 0, 0, 0);
    vecs[4]  = mk(1, 0, 10'h050, 0,        0, 1, init_val('h050), 2, 2, 4, 0, 1);
    vecs[5]  = mk(1, 0, 10'h010, 0,        1, 1, init_val('h010), 2, 3, 4, 0, 1);
    vecs[6]  = mk(1, 0, 10'h011, 0,        0, 1, 'h55,            3, 3, 0, 0, 0);
    vecs[7]  = mk(1, 1, 10'h020, 'h1234,   0, 0, 0,               3, 3, 0, 1, 1);
    vecs[8]  = mk(1, 0, 10'h020, 0,        0, 1, 'h1234,          3, 4, 4, 0, 1);
    vecs[9]  = mk(0, 1, 10'h021, 'hBEEF,   1, 0, 0,               3, 4, 0, 1, 1);
    vecs[10] = mk(1, 0, 10'h021, 0,        0, 1, 'hBEEF,          4, 4, 0, 0, 0);
    vecs[11] = mk(1, 0, 10'h013, 0,        0, 1, init_val('h013), 5, 4, 0, 0, 0);

    rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      rb = rd_hs; wb = wr_hs;
      access(vecs[i], rdata, s0, to);
      chk($sformatf("v%0d_timeout", i), to, 0);
      chk($sformatf("v%0d_stall0", i), s0, vecs[i].exp_stall0);
      if (vecs[i].chk_rdata) chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_hit_cnt", i), hit_cnt, vecs[i].exp_hit);
      chk($sformatf("v%0d_miss_cnt", i), miss_cnt, vecs[i].exp_miss);
      chk($sformatf("v%0d_mem_rd_hs", i), rd_hs - rb, vecs[i].exp_rd_hs);
      chk($sformatf("v%0d_mem_wr_hs", i), wr_hs - wb, vecs[i].exp_wr_hs);
      if (vecs[i].exp_rd_hs == 4)
        for (int k = 0; k < 4; k++) exp_log.push_back({vecs[i].addr[9:2], 2'(k)});
    end

    chk("refill_log_len", rd_log.size(), exp_log.size());
    foreach (exp_log[i])
      if (i < rd_log.size()) chk($sformatf("refill_log_%0d", i), rd_log[i], exp_log[i]);
    chk("mem_020_written", mem[10'h020], 'h1234);
    chk("mem_021_written", mem[10'h021], 'hBEEF);

    // store with three wait cycles: request and payload must hold steady
    lat = 3; wb = wr_hs;
    cpu_wr = 1'b1; cpu_addr = 10'h011; cpu_wdata = 'h77;
    @(negedge clk);
    chk("dst_idle_stall", stall, 1);
    chk("dst_idle_mem_wr", mem_wr, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("dst_wait%0d_mem_wr", k), mem_wr, 1);
      chk($sformatf("dst_wait%0d_addr", k), mem_addr, 10'h011);
      chk($sformatf("dst_wait%0d_wdata", k), mem_wdata, 'h77);
      chk($sformatf("dst_wait%0d_stall", k), stall, 1);
    end
    @(negedge clk);
    chk("dst_ready_mem_wr", mem_wr, 1);
    chk("dst_ready_stall", stall, 0);
    @(posedge clk); #1;
    cpu_wr = 1'b0;
    chk("dst_wr_hs", wr_hs - wb, 1);
    chk("dst_mem_value", mem[10'h011], 'h77);
    access(mk(1, 0, 10'h011, 0, 0, 1, 'h77, 6, 4, 0, 0, 0), rdata, s0, to);
    chk("dst_reload_timeout", to, 0);
    chk("dst_reload_stall0", s0, 0);
    chk("dst_reload_rdata", rdata, 'h77);
    chk("dst_reload_hit_cnt", hit_cnt, 6);

    // reset after the second refill word aborts the line fill
    lat = 0; rb = rd_hs;
    cpu_rd = 1'b1; cpu_addr = 10'h050;
    to = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rd_hs - rb == 2) begin
        to = 1'b0;
        break;
      end
    end
    chk("abort_reach_timeout", to, 0);
    rst = 1'b1; cpu_rd = 1'b0;
    @(negedge clk);
    chk("abort_mem_rd", mem_rd, 0);
    chk("abort_stall", stall, 0);
    chk("abort_hit_cnt", hit_cnt, 0);
    chk("abort_miss_cnt", miss_cnt, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_more_rd", rd_hs - rb, 2);
    @(posedge clk); #1;
    rst = 1'b0;
    rb = rd_hs;
    v = mk(1, 0, 10'h010, 0, 0, 1, init_val('h010), 0, 1, 4, 0, 1);
    access(v, rdata, s0, to);
    chk("post_rst_timeout", to, 0);
    chk("post_rst_stall0", s0, 1);
    chk("post_rst_rdata", rdata, v.exp_rdata);
    chk("post_rst_rd_hs", rd_hs - rb, 4);
    chk("post_rst_miss_cnt", miss_cnt, 1);
    chk("post_rst_hit_cnt", hit_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
